// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment decode for the multiplexed 7-segment driver.
package seg7_pkg;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{value: 4'h0, dp: 1'b0, blank: 1'b1};

  // Segment order {g,f,e,d,c,b,a}, active-high before polarity is applied.
  function automatic logic [6:0] seg7_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot prescaler and digit index for the scan; flags the anti-ghosting window and frame start.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] idx,
  output logic             in_blank,
  output logic             frame
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_q < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  assign idx   = idx_q;
  assign frame = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-digit 7-segment scan driver: digit register file, hex decode and a registered,
// polarity-adjusted output stage on top of seg7_scan_timer.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3:0]        wr_data,
  input  logic              wr_dp,
  input  logic              wr_blank,
  input  logic              seg_inv,
  input  logic              dig_inv,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] dig_en,
  output logic              frame_start
);

  logic [IDX_W-1:0] scan_idx;
  logic             in_blank;
  logic             frame;

  seg7_scan_timer #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .IDX_W        (IDX_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .idx      (scan_idx),
    .in_blank (in_blank),
    .frame    (frame)
  );

  digit_t dig_q [DIGITS];
  digit_t dig_d [DIGITS];

  // Out-of-range indices are dropped so a wide wr_idx can never alias a real digit.
  always_comb begin
    dig_d = dig_q;
    if (wr_en && ({1'b0, wr_idx} < (IDX_W + 1)'(DIGITS)))
      dig_d[wr_idx] = '{value: wr_data, dp: wr_dp, blank: wr_blank};
  end

  digit_t            cur;
  logic [6:0]        seg_d, seg_q;
  logic              dp_d, dp_q;
  logic [DIGITS-1:0] dig_en_d, dig_en_q;
  logic              frame_start_d, frame_start_q;

  always_comb begin
    cur           = dig_q[scan_idx];
    seg_d         = (cur.blank ? 7'h00 : seg7_decode(cur.value)) ^ {7{seg_inv}};
    dp_d          = (cur.dp & ~cur.blank) ^ seg_inv;
    dig_en_d      = (in_blank ? '0 : (DIGITS'(1) << scan_idx)) ^ {DIGITS{dig_inv}};
    frame_start_d = frame;
  end

  // Outputs park at the inactive level for the current polarity while in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) dig_q[i] <= DIGIT_RESET;
      seg_q         <= {7{seg_inv}};
      dp_q          <= seg_inv;
      dig_en_q      <= {DIGITS{dig_inv}};
      frame_start_q <= 1'b0;
    end else begin
      dig_q         <= dig_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign dig_en      = dig_en_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle scoreboard against a behavioural model plus
// table-driven hex sweep and hand sequences for reset, inversion and invalid writes.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = 2'd0;
  logic [3:0] wr_data = 4'h0;
  logic       wr_dp = 1'b0;
  logic       wr_blank = 1'b0;
  logic       seg_inv = 1'b0;
  logic       dig_inv = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] dig_en;
  logic       frame_start;

  logic       wr_en5 = 1'b0;
  logic [2:0] wr_idx5 = 3'd0;
  logic [6:0] seg5;
  logic       dp5;
  logic [4:0] dig_en5;
  logic       frame_start5;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_blank(wr_blank), .seg_inv(seg_inv), .dig_inv(dig_inv),
    .seg(seg), .dp(dp), .dig_en(dig_en), .frame_start(frame_start)
  );

  seg7_scan_driver #(.DIGITS(5), .SCAN_DIV(8), .BLANK_CYCLES(2)) u_dut5 (
    .clk(clk), .reset(reset), .wr_en(wr_en5), .wr_idx(wr_idx5), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_blank(wr_blank), .seg_inv(seg_inv), .dig_inv(dig_inv),
    .seg(seg5), .dp(dp5), .dig_en(dig_en5), .frame_start(frame_start5)
  );

  typedef struct {
    logic [3:0] value;
    logic [6:0] exp_seg;
  } vec_t;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] en;
    logic       fs;
  } out_t;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
  } mdig_t;

  vec_t  tv [16];
  out_t  sb [$];
  int    n_checks = 0;
  int    n_fail = 0;

  logic [2:0] m_cnt;
  logic [1:0] m_idx;
  mdig_t      m_dig [4];
  logic       m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic out_t model_out();
    out_t  o;
    mdig_t d;
    if (reset) begin
      o.seg = {7{seg_inv}};
      o.dp  = seg_inv;
      o.en  = {4{dig_inv}};
      o.fs  = 1'b0;
    end else begin
      d     = m_dig[m_idx];
      o.seg = (d.blank ? 7'h00 : tv[d.value].exp_seg) ^ {7{seg_inv}};
      o.dp  = (d.dp && !d.blank) ^ seg_inv;
      o.en  = ((m_cnt < 3'd2) ? 4'b0000 : (4'b0001 << m_idx)) ^ {4{dig_inv}};
      o.fs  = (m_cnt == 3'd0) && (m_idx == 2'd0);
    end
    return o;
  endfunction

  // Expected output for each edge is queued from pre-edge model state, then the model advances.
  always @(posedge clk) begin
    if (reset || m_valid) sb.push_back(model_out());
    if (reset) begin
      m_valid <= 1'b1;
      m_cnt   <= 3'd0;
      m_idx   <= 2'd0;
      for (int i = 0; i < 4; i++) m_dig[i] <= '{4'h0, 1'b0, 1'b1};
    end else begin
      m_cnt <= m_cnt + 3'd1;
      if (m_cnt == 3'd7) m_idx <= m_idx + 2'd1;
      if (wr_en) m_dig[wr_idx] <= '{wr_data, wr_dp, wr_blank};
    end
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      chk("scoreboard", {seg, dp, dig_en, frame_start}, sb[0]);
      sb.delete(0);
    end
  end

  task automatic wait_frame();
    bit found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge clk);
      found = frame_start;
    end
    chk("frame_found", found, 1);
  endtask

  // Entered on the negedge where frame_start is high; checks one whole frame.
  task automatic frame_check(input logic [6:0] s0, input logic p0, input logic [6:0] s2,
                             input logic p2, input logic si, input logic di);
    int         slot;
    logic [6:0] es;
    logic       ep;
    logic [3:0] een;
    for (int j = 0; j < 32; j++) begin
      if (j > 0) @(negedge clk);
      slot = j / 8;
      es   = (slot == 0) ? s0 : (slot == 2) ? s2 : 7'h00;
      ep   = (slot == 0) ? p0 : (slot == 2) ? p2 : 1'b0;
      een  = ((j % 8) < 2) ? 4'b0000 : (4'b0001 << slot);
      chk("frame_seg", seg, es ^ {7{si}});
      chk("frame_dp", dp, ep ^ si);
      chk("frame_en", dig_en, een ^ {4{di}});
      chk("frame_fs", frame_start, (j == 0));
    end
  endtask

  task automatic write4(input logic [1:0] i, input logic [3:0] v, input logic p, input logic b);
    wr_en = 1'b1; wr_idx = i; wr_data = v; wr_dp = p; wr_blank = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    logic [6:0] segs [16];
    segs = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 16; i++) tv[i] = '{4'(i), segs[i]};

    // Reset held 3 cycles: all outputs inactive.
    repeat (3) begin
      @(negedge clk);
      chk("rst_seg", seg, 0);
      chk("rst_dp", dp, 0);
      chk("rst_en", dig_en, 0);
      chk("rst_fs", frame_start, 0);
    end
    reset = 1'b0;

    // All digits blank; frame_start at cycles 1, 33, 65 after release.
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      chk("blank_fs", frame_start, (k % 32 == 1));
      chk("blank_seg", seg, 0);
      chk("blank_dp", dp, 0);
    end

    write4(2'd0, 4'h3, 1'b0, 1'b0);
    write4(2'd2, 4'hA, 1'b1, 1'b0);
    wait_frame();
    frame_check(7'h4F, 1'b0, 7'h77, 1'b1, 1'b0, 1'b0);

    // Hex sweep on digit 0, one value per frame, sampled at slot 0 cnt 2.
    for (int i = 0; i < 16; i++) begin
      write4(2'd0, tv[i].value, 1'b0, 1'b0);
      wait_frame();
      repeat (2) @(negedge clk);
      chk("hex_seg", seg, tv[i].exp_seg);
      chk("hex_en", dig_en, 4'b0001);
    end

    // Both polarities inverted.
    write4(2'd0, 4'h3, 1'b0, 1'b0);
    seg_inv = 1'b1;
    dig_inv = 1'b1;
    wait_frame();
    frame_check(7'h4F, 1'b0, 7'h77, 1'b1, 1'b1, 1'b1);
    seg_inv = 1'b0;
    dig_inv = 1'b0;

    // Reset sampled at slot 2 cnt 5 together with a write that must be dropped.
    wait_frame();
    repeat (20) @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b1; wr_idx = 2'd0; wr_data = 4'h8; wr_dp = 1'b1; wr_blank = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    chk("midrst_seg", seg, 0);
    chk("midrst_dp", dp, 0);
    chk("midrst_en", dig_en, 0);
    chk("midrst_fs", frame_start, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_fs", frame_start, 1);
    frame_check(7'h00, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);

    // Five-digit instance: write to index 7 must leave every digit blank.
    wr_en5 = 1'b1; wr_idx5 = 3'd7; wr_data = 4'h8; wr_dp = 1'b1; wr_blank = 1'b0;
    @(negedge clk);
    wr_en5 = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      chk("inv_idx_seg", seg5, 0);
      chk("inv_idx_dp", dp5, 0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
